// File: rtl/neuron_array_seq.sv
// neuron_array_seq: captures one KxK window and evaluates N_OUT fixed-point neurons, one tap per cycle.
// Optional build macro NEURON_ARRAY_RELU_EN clamps negative neuron outputs to zero before argmax.
module neuron_array_seq #(
   parameter  int K      = 7,
   parameter  int N_OUT  = 4,
   parameter  int DATA_W = 16,
   parameter  int WGT_W  = 16,
   parameter  int FRAC   = 8,
   parameter  int ACC_W  = 40,
   localparam int TAPS   = K * K,
   localparam int NWORD  = N_OUT * (TAPS + 1),
   localparam int AW     = (NWORD > 1) ? $clog2(NWORD) : 1,
   localparam int CW     = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      de_in,
   output logic                      ready_out,
   input  logic [TAPS*DATA_W-1:0]    win_in,
   input  logic                      wgt_we,
   input  logic [AW-1:0]             wgt_addr,
   input  logic [WGT_W-1:0]          wgt_data,
   output logic [N_OUT*DATA_W-1:0]   symbol_out,
   output logic [CW-1:0]             class_out,
   output logic                      valid_out
);

   // Handshake: a window is taken on any edge where de_in=1 and ready_out=1; de_in is ignored
   // otherwise. valid_out is a one-cycle pulse with no back-pressure; outputs hold until the next pulse.

   localparam int TW = (TAPS > 1) ? $clog2(TAPS) : 1;
   localparam int PW = DATA_W + WGT_W;
   localparam int SW = ACC_W + 1;
   localparam logic signed [SW-1:0] SAT_MAX = SW'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
   localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_FINAL = 2'd2
   } state_e;

   state_e                   state_q, state_d;
   logic [TW-1:0]            tap_q, tap_d;
   logic signed [ACC_W-1:0]  acc_q [N_OUT];
   logic signed [ACC_W-1:0]  acc_d [N_OUT];
   logic signed [DATA_W-1:0] sym_q [N_OUT];
   logic signed [DATA_W-1:0] sym_d [N_OUT];
   logic [CW-1:0]            cls_q, cls_d;
   logic                     valid_q, valid_d;

   logic signed [DATA_W-1:0] pix_q [TAPS];
   logic signed [WGT_W-1:0]  wgt_q [NWORD];

   logic                     accept;
   logic                     wr_en;
   logic signed [DATA_W-1:0] pix_cur;
   logic signed [PW-1:0]     prod [N_OUT];
   logic signed [DATA_W-1:0] fin [N_OUT];
   logic signed [DATA_W-1:0] bias_v;
   logic signed [SW-1:0]     sum_v;
   logic signed [SW-1:0]     shr_v;
   logic signed [DATA_W-1:0] best_v;
   logic [CW-1:0]            best_idx;

   assign accept    = (state_q == ST_IDLE) && de_in;
   assign wr_en     = (state_q == ST_IDLE) && wgt_we && (32'(wgt_addr) < NWORD);
   assign ready_out = (state_q == ST_IDLE);
   assign valid_out = valid_q;
   assign class_out = cls_q;

   always_comb begin
      symbol_out = '0;
      for (int n = 0; n < N_OUT; n++) begin
         symbol_out[n*DATA_W +: DATA_W] = sym_q[n];
      end
   end

   // Current tap's pixel times every neuron's weight for that tap, full precision.
   always_comb begin
      pix_cur = pix_q[tap_q];
      for (int n = 0; n < N_OUT; n++) begin
         prod[n] = pix_cur * wgt_q[AW'(n * TAPS) + AW'(tap_q)];
      end
   end

   // Bias add in the accumulator's Q format, floor shift, saturate to the output range.
   always_comb begin
      bias_v = '0;
      sum_v  = '0;
      shr_v  = '0;
      for (int n = 0; n < N_OUT; n++) begin
         bias_v = wgt_q[AW'(N_OUT * TAPS + n)][DATA_W-1:0];
         sum_v  = {acc_q[n][ACC_W-1], acc_q[n]}
                + {{(SW - DATA_W - FRAC){bias_v[DATA_W-1]}}, bias_v, {FRAC{1'b0}}};
         shr_v  = sum_v >>> FRAC;
         if (shr_v > SAT_MAX) begin
            fin[n] = SAT_MAX[DATA_W-1:0];
         end else if (shr_v < SAT_MIN) begin
            fin[n] = SAT_MIN[DATA_W-1:0];
         end else begin
            fin[n] = shr_v[DATA_W-1:0];
         end
`ifdef NEURON_ARRAY_RELU_EN
         if (fin[n] < 0) begin
            fin[n] = '0;
         end
`endif
      end
   end

   // Strict greater-than keeps the lowest index on ties.
   always_comb begin
      best_idx = '0;
      best_v   = fin[0];
      for (int n = 1; n < N_OUT; n++) begin
         if (fin[n] > best_v) begin
            best_v   = fin[n];
            best_idx = CW'(n);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      tap_d   = tap_q;
      cls_d   = cls_q;
      valid_d = 1'b0;
      for (int n = 0; n < N_OUT; n++) begin
         acc_d[n] = acc_q[n];
         sym_d[n] = sym_q[n];
      end
      case (state_q)
         ST_IDLE: begin
            if (de_in) begin
               state_d = ST_ACCUM;
               tap_d   = '0;
               for (int n = 0; n < N_OUT; n++) begin
                  acc_d[n] = '0;
               end
            end
         end
         ST_ACCUM: begin
            for (int n = 0; n < N_OUT; n++) begin
               acc_d[n] = acc_q[n] + {{(ACC_W - PW){prod[n][PW-1]}}, prod[n]};
            end
            if (tap_q == TW'(TAPS - 1)) begin
               state_d = ST_FINAL;
               tap_d   = '0;
            end else begin
               tap_d = tap_q + 1'b1;
            end
         end
         ST_FINAL: begin
            for (int n = 0; n < N_OUT; n++) begin
               sym_d[n] = fin[n];
            end
            cls_d   = best_idx;
            valid_d = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         tap_q   <= '0;
         cls_q   <= '0;
         valid_q <= 1'b0;
         for (int n = 0; n < N_OUT; n++) begin
            acc_q[n] <= '0;
            sym_q[n] <= '0;
         end
      end else begin
         state_q <= state_d;
         tap_q   <= tap_d;
         cls_q   <= cls_d;
         valid_q <= valid_d;
         for (int n = 0; n < N_OUT; n++) begin
            acc_q[n] <= acc_d[n];
            sym_q[n] <= sym_d[n];
         end
      end
   end

   // Window and coefficient storage survive reset; only idle-time writes land.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int t = 0; t < TAPS; t++) begin
            pix_q[t] <= win_in[(TAPS-1-t)*DATA_W +: DATA_W];
         end
      end
      if (wr_en) begin
         wgt_q[wgt_addr] <= wgt_data;
      end
   end

endmodule

// File: doc/neuron_array_seq.md
Name: neuron_array_seq

Overview:
- Parametrised successor to the single-window neuron unit.
- Captures one KxK pixel window on a de_in handshake. Computes N_OUT fixed-point neurons (weighted sum + bias, saturate) with one tap per cycle, all neurons in parallel.
- Presents the flattened neuron outputs plus an argmax class index with a one-cycle valid pulse.
- Sits between the line-buffer window generator and the symbol-decision logic. Weights and biases are loaded at runtime through a write port.

Parameters:
K, 7, window side; K*K taps per neuron
N_OUT, 4, number of output neurons (symbols)
DATA_W, 16, signed pixel/output width, Qx.FRAC
WGT_W, 16, signed weight width, Qx.FRAC
FRAC, 8, fractional bits of data, weight and bias
ACC_W, 40, signed accumulator width; must be >= DATA_W+WGT_W+clog2(K*K+1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
de_in  in  1  window valid
ready_out  out  1  block idle, de_in will be accepted
win_in  in  K*K*DATA_W  window; pixel (r,c), t=r*K+c, at bits [(K*K-1-t)*DATA_W +: DATA_W] (row 0/col 0 in MSBs)
wgt_we  in  1  weight/bias write strobe
wgt_addr  in  AW=clog2(N_OUT*(K*K+1))  addr n*K*K+t = weight(n,t); addr N_OUT*K*K+n = bias(n)
wgt_data  in  WGT_W  write data (bias uses low DATA_W bits, signed)
symbol_out  out  N_OUT*DATA_W  neuron n at bits [n*DATA_W +: DATA_W]
class_out  out  clog2(N_OUT) (min 1)  argmax index
valid_out  out  1  one-cycle pulse, outputs updated

Behaviour:
- States: IDLE, ACCUM, FINAL.
  - IDLE: ready_out=1. Edge with de_in=1 (E0) latches win_in, clears accumulators, tap counter=0, -> ACCUM.
  - ACCUM: each edge adds pixel(t)*weight(n,t) to acc[n] for all n; t++. On the edge at t=K*K-1 -> FINAL. Occupies edges E1..E(K*K).
  - FINAL: edge E(K*K+1) registers symbol_out/class_out, sets valid_out=1 for exactly one cycle, -> IDLE (ready_out=1 same cycle).
- Latency: de_in accept to valid_out = K*K+1 edges; throughput one window per K*K+2 cycles (accept edge included).
- Arithmetic:
  - Products are full DATA_W+WGT_W signed, sign-extended to ACC_W; no wrap.
  - Final: acc + (bias sign-extended, <<FRAC), then arithmetic >>FRAC (floor), then saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Argmax over the final saturated values, signed compare; ties resolve to the lowest index.
- de_in while not IDLE: ignored, no queueing; ready_out=0 throughout ACCUM and FINAL.
- wgt_we:
  - Written on the edge only when state is IDLE; ignored otherwise.
  - Addresses >= N_OUT*(K*K+1) are ignored.
  - Same-edge wgt_we and de_in in IDLE: the write lands, and the accepted window uses the new value.
- Reset (any state, incl. mid-ACCUM):
  - Next cycle: state IDLE, ready_out=1, valid_out=0, symbol_out=0, class_out=0, accumulators and tap counter 0.
  - Weight/bias storage is not cleared by reset.
- symbol_out/class_out hold their values between valid pulses.

Optional Feature:
- Macro NEURON_ARRAY_RELU_EN.
- Defined: in FINAL, any neuron value < 0 after saturation is forced to 0 before registering and before argmax. An all-negative window therefore gives all zeros and class_out=0.
- Undefined: linear saturated output, negatives preserved.

Test Plan:
- Reset behaviour: assert reset 2 cycles, then release -> ready_out=1, valid_out=0, symbol_out=0, class_out=0. Repeat with reset asserted at ACCUM t=10 -> IDLE next cycle, no valid_out.
- Single-tap identity (defaults): weight(0,24)=0x0100, all others and biases 0; centre pixel 0x0280, others 0x0100.
  - de_in accepted at E0 -> valid_out exactly 50 edges later.
  - symbol 0 = 0x0280, symbols 1-3 = 0, class_out=0.
- Full-sum with bias: neuron 2 weights all 0x0100, bias 0x0100, all pixels 0x0100 -> symbol 2 = 0x3200 (50.0), class_out=2.
- Saturation: all weights 0x7FFF, pixels 0x7FFF -> all symbols 0x7FFF. Negate weights (0x8001) -> 0x8000 without the macro, 0x0000 with NEURON_ARRAY_RELU_EN.
- Busy protection: pulse de_in and wgt_we at ACCUM t=5 -> result equals the undisturbed run, and the weight readback effect is absent on the next window.
- Argmax tie and small config (K=3, N_OUT=2): neurons 0 and 1 both 0x0100 -> class_out=0; valid_out 10 edges after accept.
